mem_port_arbiter: RTL
=====================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 The block SHALL have parameter STARVE_LIMIT, default 4: maximum consecutive data-port grants while a fetch request waits.
REQ-002 The block SHALL have one clock and an asynchronous active-low reset: clk input 1 (all state on rising edge); reset input 1 (asynchronous, active-low).
REQ-003 The block SHALL have these fetch-port signals:
- if_req input 1: fetch request.
- if_addr input 32: fetch address.
- if_gnt output 1: fetch accepted.
- if_rdata output 32: fetched instruction.
- if_rvalid output 1: fetch data valid.
REQ-004 The block SHALL have these data-port signals:
- dm_req input 1: data request.
- dm_we input 1: write enable.
- dm_addr input 32: data address.
- dm_wdata input 32: store data.
- dm_gnt output 1: data accepted.
- dm_rdata output 32: load data.
- dm_rvalid output 1: access complete.
REQ-005 The block SHALL have these memory-side signals:
- mem_req output 1.
- mem_we output 1.
- mem_addr output 32.
- mem_wdata output 32.
- mem_ack input 1: access done; mem_rdata valid.
- mem_rdata input 32.
REQ-006 The block SHALL have stall outputs stall_if and stall_dm, output 1 each: pipeline stall requests.

Function
REQ-007 The FSM SHALL have states IDLE, BUSY_IF and BUSY_DM.
REQ-008 In IDLE, a grant SHALL be combinational: dm_gnt=dm_req; if_gnt=if_req & ~dm_req, except under REQ-013.
- At most one grant per cycle.
REQ-009 On a grant, the block SHALL register addr/we/wdata (we=0 for fetch) and move to BUSY_IF or BUSY_DM at the next edge.
REQ-010 In BUSY_x, mem_req SHALL be 1 and mem_addr/mem_we/mem_wdata SHALL be driven from registers.
- In IDLE, mem_req=0 and mem_we=0.
REQ-011 On mem_ack in BUSY_x:
- mem_rdata SHALL be captured into x_rdata.
- x_rvalid SHALL pulse one cycle at the next edge.
- The FSM SHALL return to IDLE.
- No grant is issued in the ack cycle.
- Minimum turnaround: grant cycle N, mem_req cycle N+1, ack cycle N+1, rvalid cycle N+2, next grant cycle N+2.
REQ-012 dm_rvalid SHALL pulse for writes as well as reads; dm_rdata SHALL be unchanged on writes.
REQ-013 The starvation counter SHALL behave as follows:
- Increment on each dm grant while if_req=1.
- Clear on an if grant, or on any cycle with if_req=0.
- When it equals STARVE_LIMIT and both requests are present in IDLE, if_gnt=1 and dm_gnt=0.
- Width: $clog2(STARVE_LIMIT+1); saturates, never wraps.
REQ-014 stall_if SHALL be if_req & ~if_rvalid; stall_dm SHALL be dm_req & ~dm_rvalid.
REQ-015 A request deasserted before its grant SHALL be dropped with no memory access.
- Requesters hold req/addr/data stable until grant.
REQ-016 mem_ack SHALL be ignored in IDLE.
REQ-017 if_rdata and dm_rdata SHALL hold their last value until overwritten.

Reset
REQ-018 While reset=0, the block SHALL asynchronously force:
- state IDLE.
- mem_req, mem_we, if_gnt, dm_gnt, if_rvalid, dm_rvalid = 0.
- rdata/addr/wdata registers = 0.
- starvation counter = 0.
REQ-019 Reset during BUSY_x SHALL abandon the access: no rvalid pulse, and mem_req drops immediately.

Configuration
REQ-020 With ARB_STARVE_GUARD_EN defined, REQ-013 SHALL apply.
- Without it, there is no counter and strict data-port priority always applies.
- STARVE_LIMIT is then unused.

Structure
REQ-021 Package arb_pkg SHALL hold:
- the state enum arb_state_t {IDLE, BUSY_IF, BUSY_DM}.
- the port-select typedef.
- the default STARVE_LIMIT constant.
REQ-022 The starvation counter SHALL be sub-module arb_starve_ctr, instantiated only under ARB_STARVE_GUARD_EN.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- Fetch-only read: if_req=1, if_addr=0x10, mem_ack after 1 cycle with mem_rdata=0xE3A01005 -> if_gnt cycle 0, mem_addr=0x10 cycle 1, if_rvalid and if_rdata=0xE3A01005 cycle 2.
- Simultaneous requests: if_req=1, dm_req=1, dm_we=1, dm_addr=0x40, dm_wdata=0xDEAD -> dm_gnt only; mem_we=1 with 0x40/0xDEAD; dm_rvalid after ack; stall_if=1 throughout.
- Starvation (macro on, STARVE_LIMIT=4): both requests held continuously -> 4 dm grants then 1 if grant, repeating. With the macro off, if_gnt never asserts.
- Slow memory: mem_ack delayed 5 cycles -> mem_req held 5 cycles, addr stable, no new grant, single rvalid.
- Reset mid-access: reset=0 in BUSY_DM before ack -> mem_req=0 immediately, no dm_rvalid, IDLE after release.
- Withdrawn request: dm_req pulsed 1 cycle while BUSY_IF -> no dm access ever issued.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared types and defaults for the fetch/data memory-port arbiter.
// Optional starvation guard is enabled by defining ARB_STARVE_GUARD_EN.
package arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_DM = 2'd2
  } arb_state_t;

  typedef enum logic {
    PORT_IF = 1'b0,
    PORT_DM = 1'b1
  } arb_port_t;

  localparam int STARVE_LIMIT_DEF = 4;

endpackage

// File: rtl/mem_port_arbiter_starve_ctr.sv
// Saturating count of data-port grants issued while a fetch waits; flags when
// the fetch port must be given the next grant. Built only with ARB_STARVE_GUARD_EN.
module arb_starve_ctr #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic if_req_i,
  input  logic if_gnt_i,
  input  logic dm_gnt_i,
  output logic starved_o
);

  localparam int W = $clog2(STARVE_LIMIT + 1);
  localparam logic [W-1:0] LIMIT = W'(STARVE_LIMIT);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (if_gnt_i || !if_req_i) begin
      cnt_q <= '0;
    end else if (dm_gnt_i && (cnt_q != LIMIT)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign starved_o = (cnt_q == LIMIT);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch and data ports onto one memory port; data port has priority.
// Define ARB_STARVE_GUARD_EN to let a waiting fetch win after STARVE_LIMIT data grants.
module mem_port_arbiter
  import arb_pkg::*;
#(
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic [31:0] if_rdata,
  output logic        if_rvalid,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  output logic        dm_gnt,
  output logic [31:0] dm_rdata,
  output logic        dm_rvalid,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        stall_if,
  output logic        stall_dm
);

  arb_state_t  state_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        we_q;
  logic [31:0] if_rdata_q;
  logic [31:0] dm_rdata_q;
  logic        if_rvalid_q;
  logic        dm_rvalid_q;

  logic        starved;
  logic        gnt_vld;
  arb_port_t   gnt_sel;

`ifdef ARB_STARVE_GUARD_EN
  arb_starve_ctr #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_starve_ctr (
    .clk       (clk),
    .rst_n     (reset),
    .if_req_i  (if_req),
    .if_gnt_i  (if_gnt),
    .dm_gnt_i  (dm_gnt),
    .starved_o (starved)
  );
`else
  logic [31:0] unused_starve_limit;
  assign unused_starve_limit = 32'(STARVE_LIMIT);
  assign starved = 1'b0;
`endif

  // Grants are only offered from IDLE, so the ack cycle never grants.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_sel = PORT_DM;
    if (reset && (state_q == IDLE)) begin
      if (if_req && (!dm_req || starved)) begin
        gnt_vld = 1'b1;
        gnt_sel = PORT_IF;
      end else if (dm_req) begin
        gnt_vld = 1'b1;
        gnt_sel = PORT_DM;
      end
    end
  end

  assign if_gnt = gnt_vld && (gnt_sel == PORT_IF);
  assign dm_gnt = gnt_vld && (gnt_sel == PORT_DM);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      we_q        <= 1'b0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      if_rvalid_q <= 1'b0;
      dm_rvalid_q <= 1'b0;
    end else begin
      if_rvalid_q <= 1'b0;
      dm_rvalid_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (dm_gnt) begin
            state_q <= BUSY_DM;
            addr_q  <= dm_addr;
            we_q    <= dm_we;
            wdata_q <= dm_wdata;
          end else if (if_gnt) begin
            state_q <= BUSY_IF;
            addr_q  <= if_addr;
            we_q    <= 1'b0;
            wdata_q <= '0;
          end
        end
        BUSY_IF: begin
          if (mem_ack) begin
            if_rdata_q  <= mem_rdata;
            if_rvalid_q <= 1'b1;
            state_q     <= IDLE;
          end
        end
        BUSY_DM: begin
          if (mem_ack) begin
            // Stores complete with a pulse but leave the load data intact.
            if (!we_q) dm_rdata_q <= mem_rdata;
            dm_rvalid_q <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_req   = (state_q != IDLE);
  assign mem_we    = (state_q == BUSY_DM) && we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;
  assign if_rvalid = if_rvalid_q;
  assign dm_rvalid = dm_rvalid_q;

  assign stall_if  = if_req && !if_rvalid_q;
  assign stall_dm  = dm_req && !dm_rvalid_q;

endmodule
